// File: rtl/color_ratio_meter.sv
// color_ratio_meter: counts rising edges on NUM_CH colour channels and one
// reference channel over a fixed gate window. Each window it publishes every
// channel's percentage of the reference, clamped to 100, plus per-channel
// in-window flags.
// Optional build macro AUTO_SCALE_EN: steps the sensor scaling code down or up
// from the reference count at each publish. Without it, scale is SCALE_INIT.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for the gate window terminal cycle (snapshot)
// S_DIVIDE  | computing pct_k = min(100, cnt_k*100/ref), one channel at a time
// S_COMPARE | window compare, register outputs, pulse valid next cycle
module color_ratio_meter #(
    parameter int         NUM_CH      = 3,
    parameter int         CNT_W       = 16,
    parameter int         GATE_CYCLES = 100000,
    parameter logic [1:0] SCALE_INIT  = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     sensor_freq,
    input  logic                  ref_freq,
    input  logic [NUM_CH*7-1:0]   lo_pct,
    input  logic [NUM_CH*7-1:0]   hi_pct,
    output logic [1:0]            scale,
    output logic [NUM_CH*7-1:0]   pct_out,
    output logic [NUM_CH-1:0]     match,
    output logic                  valid,
    output logic                  overflow
);

    localparam int DW = CNT_W + 7;
    localparam int BW = $clog2(DW + 1);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_COMPARE
    } state_t;

    state_t state, state_nxt;

    // channel NUM_CH is the reference channel in all per-channel vectors
    logic [NUM_CH:0]    sync1, sync2, sync3;
    logic [NUM_CH:0]    rise;

    logic [GW-1:0]      gate_cnt;
    logic               gate_tc;

    logic [CNT_W-1:0]   cnt      [NUM_CH+1];
    logic [CNT_W-1:0]   cnt_inc  [NUM_CH+1];
    logic               any_sat;
    logic               window_ovf;

    logic [CNT_W-1:0]   snap_cnt [NUM_CH];
    logic [CNT_W-1:0]   snap_ref;
    logic               snap_ovf;
    logic               missed;

    logic [KW-1:0]      k_idx;
    logic               k_last;
    logic               div_busy;
    logic [BW-1:0]      div_bits;
    logic [DW-1:0]      quo;
    logic [CNT_W-1:0]   rem;
    logic [CNT_W:0]     shifted;
    logic               ge;
    logic [CNT_W-1:0]   rem_nxt;
    logic [DW-1:0]      quo_nxt;
    logic [6:0]         pct_clamped;
    logic               ch_done;

    logic [6:0]         pct_calc [NUM_CH];
    logic [NUM_CH*7-1:0] pct_packed;
    logic [NUM_CH-1:0]  match_nxt;

    assign rise    = sync2 & ~sync3;
    assign gate_tc = (gate_cnt == GW'(GATE_CYCLES - 1));
    assign k_last  = (k_idx == KW'(NUM_CH - 1));

    // two-flop synchronisers plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= {ref_freq, sensor_freq};
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // gate window counter, wraps after GATE_CYCLES-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (gate_tc) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GW'(1);
        end
    end

    // saturating increment; an edge on the terminal cycle is still counted
    always_comb begin
        any_sat = 1'b0;
        for (int i = 0; i <= NUM_CH; i++) begin
            cnt_inc[i] = cnt[i];
            if (rise[i] && (cnt[i] != CNT_MAX)) begin
                cnt_inc[i] = cnt[i] + CNT_W'(1);
            end
            if (cnt_inc[i] == CNT_MAX) begin
                any_sat = 1'b1;
            end
        end
    end

    // edge counters and sticky saturation flag, cleared after each window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            window_ovf <= 1'b0;
        end else if (gate_tc) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt[i] <= '0;
            end
            window_ovf <= 1'b0;
        end else begin
            for (int i = 0; i <= NUM_CH; i++) begin
                cnt[i] <= cnt_inc[i];
            end
            window_ovf <= window_ovf | any_sat;
        end
    end

    // snapshot at window end; a snapshot while busy is dropped and remembered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap_cnt[i] <= '0;
            end
            snap_ref <= '0;
            snap_ovf <= 1'b0;
            missed   <= 1'b0;
        end else begin
            if (state == S_COMPARE) begin
                missed <= 1'b0;
            end
            if (gate_tc) begin
                if (state == S_IDLE) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        snap_cnt[i] <= cnt_inc[i];
                    end
                    snap_ref <= cnt_inc[NUM_CH];
                    snap_ovf <= window_ovf | any_sat;
                end else begin
                    missed <= 1'b1;
                end
            end
        end
    end

    // one restoring-division step: quotient bits shift into quo from the right
    always_comb begin
        shifted     = {rem, quo[DW-1]};
        ge          = (shifted >= {1'b0, snap_ref});
        rem_nxt     = ge ? CNT_W'(shifted - {1'b0, snap_ref}) : shifted[CNT_W-1:0];
        quo_nxt     = {quo[DW-2:0], ge};
        pct_clamped = (quo_nxt > DW'(100)) ? 7'd100 : quo_nxt[6:0];
        ch_done     = (state == S_DIVIDE) &&
                      ((!div_busy && (snap_ref == '0)) ||
                       (div_busy && (div_bits == BW'(1))));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (gate_tc) state_nxt = S_DIVIDE;
            S_DIVIDE:  if (ch_done && k_last) state_nxt = S_COMPARE;
            S_COMPARE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // divider datapath: one load cycle then DW iterations per channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_idx    <= '0;
            div_busy <= 1'b0;
            div_bits <= '0;
            quo      <= '0;
            rem      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pct_calc[i] <= '0;
            end
        end else if (state == S_DIVIDE) begin
            if (!div_busy) begin
                if (snap_ref == '0) begin
                    pct_calc[k_idx] <= '0;
                    k_idx           <= k_last ? '0 : k_idx + KW'(1);
                end else begin
                    quo      <= DW'(snap_cnt[k_idx]) * DW'(100);
                    rem      <= '0;
                    div_bits <= BW'(DW);
                    div_busy <= 1'b1;
                end
            end else begin
                quo      <= quo_nxt;
                rem      <= rem_nxt;
                div_bits <= div_bits - BW'(1);
                if (div_bits == BW'(1)) begin
                    pct_calc[k_idx] <= pct_clamped;
                    div_busy        <= 1'b0;
                    k_idx           <= k_last ? '0 : k_idx + KW'(1);
                end
            end
        end else begin
            k_idx    <= '0;
            div_busy <= 1'b0;
        end
    end

    // strict window compare and output packing
    always_comb begin
        pct_packed = '0;
        match_nxt  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pct_packed[7*k +: 7] = pct_calc[k];
            match_nxt[k] = (lo_pct[7*k +: 7] < pct_calc[k]) &&
                           (pct_calc[k] < hi_pct[7*k +: 7]);
        end
    end

    // publish registers; outputs hold between publishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pct_out  <= '0;
            match    <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= (state == S_COMPARE);
            if (state == S_COMPARE) begin
                pct_out  <= pct_packed;
                match    <= match_nxt;
                overflow <= snap_ovf | missed;
            end
        end
    end

`ifdef AUTO_SCALE_EN
    localparam int HI_THR = 3 * ((1 << CNT_W) - 1);
    localparam int LO_THR = (1 << CNT_W) / 16;

    logic ref_high, ref_low;

    assign ref_high = ({snap_ref, 2'b00} >= (CNT_W+2)'(HI_THR)) || (snap_ref == CNT_MAX);
    assign ref_low  = (snap_ref < CNT_W'(LO_THR));

    // scale steps on the valid cycle, so the new code appears the cycle after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale <= SCALE_INIT;
        end else if (valid) begin
            if (ref_high) begin
                if (scale > 2'b01) scale <= scale - 2'b01;
            end else if (ref_low) begin
                if (scale < 2'b11) scale <= scale + 2'b01;
            end
        end
    end
`else
    assign scale = SCALE_INIT;
`endif

endmodule
